// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline controller and the stage registers / exception logic.
// The master modport is the controller side; the slave modport is the pipeline side.
interface pipe_ctrl_if #(
  parameter int unsigned CW = 6
);
  logic          id_stall_req;
  logic          ex_mc_start;
  logic          excp_valid;
  logic [31:0]   excp_vector;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic          mc_busy;
  logic          mc_done;
  logic          mc_abort;
  logic [CW-1:0] mc_iter;
  logic [31:0]   stall_cnt;

  modport master (
    input  id_stall_req, ex_mc_start, excp_valid, excp_vector,
    output stall, flush, new_pc, mc_busy, mc_done, mc_abort, mc_iter, stall_cnt
  );

  modport slave (
    output id_stall_req, ex_mc_start, excp_valid, excp_vector,
    input  stall, flush, new_pc, mc_busy, mc_done, mc_abort, mc_iter, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges ID/EX stall requests, sequences the EX multi-cycle window,
// handles exception flushes and counts stalled cycles.
module pipe_ctrl #(
  parameter int unsigned MC_CYCLES = 32,
  parameter int unsigned CW        = 6
) (
  input logic          clk,
  input logic          rst_,
  pipe_ctrl_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [5:0]    StallEx = 6'b001111;
  localparam logic [5:0]    StallId = 6'b000111;
  localparam logic [CW-1:0] IterLast = CW'(MC_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] mc_iter_q, mc_iter_d;
  logic [31:0]   stall_cnt_q;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
  logic        mc_abort;

  always_comb begin
    state_d   = state_q;
    mc_iter_d = mc_iter_q;
    stall     = '0;
    flush     = 1'b0;
    new_pc    = '0;
    mc_busy   = 1'b0;
    mc_done   = 1'b0;
    mc_abort  = 1'b0;

    // Outputs stay quiet while reset is held; the state register handles the reset itself.
    if (!rst_) begin
      if (bus.excp_valid) begin
        flush     = 1'b1;
        new_pc    = bus.excp_vector;
        state_d   = StIdle;
        mc_iter_d = '0;
        mc_abort  = (state_q == StBusy) || ((state_q == StIdle) && bus.ex_mc_start);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.ex_mc_start) begin
              stall     = StallEx;
              state_d   = StBusy;
              mc_iter_d = CW'(1);
            end else if (bus.id_stall_req) begin
              stall = StallId;
            end
          end
          StBusy: begin
            stall   = StallEx;
            mc_busy = 1'b1;
            if (mc_iter_q == IterLast) begin
              state_d   = StDone;
              mc_iter_d = '0;
            end else begin
              mc_iter_d = mc_iter_q + 1'b1;
            end
          end
          StDone: begin
            // EX is released so the result moves on; ex_mc_start still belongs to this op.
            mc_done = 1'b1;
            state_d = StIdle;
            if (bus.id_stall_req) begin
              stall = StallId;
            end
          end
          default: begin
            state_d   = StIdle;
            mc_iter_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q     <= StIdle;
      mc_iter_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mc_iter_q <= mc_iter_d;
      if (stall[0] && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.new_pc    = new_pc;
  assign bus.mc_busy   = mc_busy;
  assign bus.mc_done   = mc_done;
  assign bus.mc_abort  = mc_abort;
  assign bus.mc_iter   = mc_iter_q;
  assign bus.stall_cnt = stall_cnt_q;

  mc_iter_range_a: assert property (@(posedge clk) disable iff (rst_)
    32'(mc_iter_q) < MC_CYCLES);

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage core (IF, ID, EX, MEM, WB). It merges stall requests from ID (load-use hazard) and EX (multi-cycle ops such as div/madd), and sequences the EX multi-cycle window with an internal FSM and iteration counter. It also handles exception flushes and drives the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers. It includes a saturating stall-cycle performance counter.

Parameters:
MC_CYCLES, 32, number of EX cycles a multi-cycle op occupies (legal range 2..63).
CW, 6, width of the iteration counter; must satisfy 2^CW > MC_CYCLES.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_  input  1  reset, synchronous, active-high.
id_stall_req  input  1  ID load-use hazard; the instruction in ID must wait.
ex_mc_start  input  1  the instruction in EX is a multi-cycle op; sampled only in IDLE.
excp_valid  input  1  exception taken in MEM; the pipeline must be flushed.
excp_vector  input  32  handler address for the exception.
stall  output  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved (always 0); 1 = hold the register.
flush  output  1  clear all pipeline registers this cycle.
new_pc  output  32  pc load value, valid when flush=1; otherwise 0.
mc_busy  output  1  EX multi-cycle unit is iterating.
mc_done  output  1  one-cycle pulse: multi-cycle result is valid in EX this cycle.
mc_abort  output  1  one-cycle pulse: multi-cycle op killed by flush.
mc_iter  output  CW  current iteration index, 0 when not busy.
stall_cnt  output  32  number of cycles with stall[0]=1, saturating at 0xFFFFFFFF.

Behaviour:
- Reset (rst_=1 at a rising edge):
  - state=IDLE, mc_iter=0, stall_cnt=0.
  - While rst_ is high: stall=0, flush=0, new_pc=0, mc_busy=0, mc_done=0, mc_abort=0.
- FSM states: IDLE, BUSY, DONE. Next state is registered; stall, flush, new_pc and the pulses are combinational from the current state and inputs.
- Priority within a cycle: flush > EX multi-cycle > ID stall.
- Flush (excp_valid=1):
  - flush=1, new_pc=excp_vector, stall=6'b000000 in the same cycle.
  - Next state is IDLE and mc_iter is cleared.
  - mc_abort=1 if the current state is BUSY, or the state is IDLE with ex_mc_start=1.
  - mc_done is suppressed.
  - A flush held for N cycles produces N flush cycles.
- IDLE:
  - ex_mc_start=1 and no flush: stall=6'b001111, next state BUSY, mc_iter<=1.
  - Otherwise, id_stall_req=1: stall=6'b000111. The id_ex register is loaded with a bubble by its owner, which is not this block.
  - Otherwise stall=0.
- BUSY:
  - stall=6'b001111, mc_busy=1. id_stall_req is ignored because it is masked by the EX stall.
  - Each cycle mc_iter increments.
  - When mc_iter==MC_CYCLES-1, next state is DONE; mc_iter<=0 on that transition.
  - The total stall length from the ex_mc_start cycle is exactly MC_CYCLES cycles.
- DONE:
  - mc_done=1, mc_busy=0. EX stalls are released so the result advances into ex_mem.
  - stall=6'b000111 if id_stall_req=1, otherwise 0.
  - ex_mc_start is ignored (it belongs to the completing op). Next state is IDLE.
- Back-to-back multi-cycle ops: the next op is sampled in the IDLE cycle after DONE. This gives one free cycle between windows.
- stall_cnt: increments on every non-reset cycle where stall[0]=1 and flush=0, and holds at 0xFFFFFFFF.
- Reset asserted mid-BUSY returns the block to IDLE on that edge with no mc_abort pulse.
- mc_iter values outside 0..MC_CYCLES-1 are unreachable. A simulation assertion must check this.

Test Plan:
1. Reset, then idle inputs for 5 cycles -> stall=0, flush=0, new_pc=0, stall_cnt=0, mc_iter=0.
2. id_stall_req=1 for 2 cycles in IDLE -> stall=6'b000111 for exactly those 2 cycles; stall_cnt=2.
3. MC_CYCLES=4, ex_mc_start pulse at cycle t:
   - stall=6'b001111 for cycles t..t+3.
   - mc_iter=1,2,3 at t+1..t+3.
   - mc_done=1 only at t+4, with stall=0.
   - IDLE at t+5; stall_cnt=4.
4. MC_CYCLES=4, excp_valid=1 with excp_vector=0x00000020 at BUSY mc_iter=2:
   - flush=1, new_pc=0x20, stall=0, mc_abort=1 that cycle.
   - Next cycle IDLE, mc_iter=0, no mc_done.
5. Same cycle ex_mc_start=1, id_stall_req=1, excp_valid=1 in IDLE -> flush wins: stall=0, mc_abort=1; next cycle id_stall_req alone gives stall=6'b000111.
6. Reset mid-BUSY (mc_iter=2) -> state IDLE, all outputs 0, stall_cnt=0, no mc_done/mc_abort.
   - Separately, force stall_cnt to 0xFFFFFFFE plus 3 stall cycles -> stall_cnt saturates at 0xFFFFFFFF.
